// File: rtl/riscv_div_ctrl.sv
// Sequencer around an unsigned long-division core for RISC-V DIV/DIVU/REM/REMU.
// Handles operand sign folding, divide-by-zero and signed-overflow bypass, and result sign fix-up.
module riscv_div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             div_start,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic             div_valid,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    FIX   = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic               rem_r, sx_r, sy_r;
  logic [TAG_W-1:0]   tag_r;
  logic [31:0]        x_r, y_r, data_r;

  logic               accept_s, signed_s, s1_s, s2_s, bypass_s;
  logic [31:0]        byp_data_s, fix_mag_s, fix_data_s;
  logic               fix_neg_s;

  // Two's-complement magnitude; 0x80000000 maps onto itself.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign accept_s = req_valid && (state_r == IDLE);

  // Request decode: sign flags, bypass detection and bypass result.
  always_comb begin
    signed_s   = ~req_funct3[0];
    s1_s       = signed_s & req_rs1[31];
    s2_s       = signed_s & req_rs2[31];
    bypass_s   = 1'b0;
    byp_data_s = 32'd0;
    if (req_rs2 == 32'd0) begin
      bypass_s   = 1'b1;
      byp_data_s = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (signed_s && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF)) begin
      bypass_s   = 1'b1;
      byp_data_s = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      bypass_s   = 1'b0;
      byp_data_s = 32'd0;
    end
  end

  // Result fix-up: quotient sign follows the operand XOR, remainder follows the dividend.
  always_comb begin
    fix_mag_s  = rem_r ? div_r : div_q;
    fix_neg_s  = rem_r ? sx_r : (sx_r ^ sy_r);
    fix_data_s = cond_neg(fix_mag_s, fix_neg_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = bypass_s ? RESP : START;
        end else begin
          state_s = IDLE;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        if (div_valid) begin
          state_s = FIX;
        end else begin
          state_s = WAIT;
        end
      end
      FIX: state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      rem_r   <= 1'b0;
      sx_r    <= 1'b0;
      sy_r    <= 1'b0;
      tag_r   <= '0;
      x_r     <= 32'd0;
      y_r     <= 32'd0;
      data_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        rem_r <= req_funct3[1];
        sx_r  <= s1_s;
        sy_r  <= s2_s;
        tag_r <= req_tag;
        x_r   <= cond_neg(req_rs1, s1_s);
        y_r   <= cond_neg(req_rs2, s2_s);
        if (bypass_s) begin
          data_r <= byp_data_s;
        end
      end
      if (state_r == FIX) begin
        data_r <= fix_data_s;
      end
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);
  assign div_start  = (state_r == START);
  assign resp_data  = data_r;
  assign resp_tag   = tag_r;
  assign div_x      = x_r;
  assign div_y      = y_r;

endmodule

// File: doc/riscv_div_ctrl.md
RISCV_DIV_CTRL -- requirements
Module: riscv_div_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, giving the destination-register tag width.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-006 The block SHALL have port req_funct3, input, 3 bits: operation select; 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have ports req_rs1 and req_rs2, input, 32 bits each: dividend and divisor.
REQ-008 The block SHALL have port req_tag, input, TAG_W bits: destination tag.
REQ-009 The block SHALL have port resp_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port resp_data, output, 32 bits: the result.
REQ-012 The block SHALL have port resp_tag, output, TAG_W bits: the tag of the result.
REQ-013 The block SHALL have port div_start, output, 1 bit: single-cycle start to the unsigned long-division core.
REQ-014 The block SHALL have ports div_x and div_y, output, 32 bits each: unsigned dividend and divisor to the core.
REQ-015 The block SHALL have port div_valid, input, 1 bit: core result valid (sticky until the next start).
REQ-016 The block SHALL have ports div_q and div_r, input, 32 bits each: core quotient and remainder.

Function
REQ-017 The block SHALL implement the states IDLE, START, WAIT, FIX and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with req_valid && req_ready.
REQ-019 On accept, the block SHALL register funct3 and tag, and register the sign flags: signed ops (DIV/REM) use rs1[31]/rs2[31]; unsigned ops use 0.
REQ-020 On accept, the block SHALL register div_x = |rs1| and div_y = |rs2|, where magnitude is two's-complement negation when the sign flag is set; |0x80000000| = 0x80000000.
REQ-021 Bypass: if rs2 == 0, the block SHALL go IDLE->RESP directly with resp_data = 0xFFFFFFFF for DIV/DIVU and resp_data = rs1 for REM/REMU.
REQ-022 Bypass: for signed ops with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF, the block SHALL go IDLE->RESP with resp_data = 0x80000000 for DIV and 0 for REM.
REQ-023 Otherwise IDLE SHALL go to START; div_start SHALL be 1 exactly in START (one cycle), and START SHALL go to WAIT.
REQ-024 In WAIT the block SHALL stay until div_valid = 1, then go to FIX; div_valid is never sampled in START.
REQ-025 In FIX, the result magnitude SHALL be div_q for DIV/DIVU and div_r for REM/REMU.
REQ-026 In FIX, the block SHALL negate the result for DIV when the sign flags differ, and for REM when the dividend sign flag is set; it SHALL then register resp_data and go to RESP.
REQ-027 In RESP, resp_valid SHALL be 1; resp_data and resp_tag SHALL hold stable until resp_valid && resp_ready, then the block SHALL return to IDLE.
REQ-028 No request is accepted in the RESP cycle.
REQ-029 Latency, with resp_ready held high, SHALL be: normal path 35 cycles from the accept edge to resp_valid high; bypass path 1 cycle.
REQ-030 div_x and div_y SHALL hold constant from accept until the block leaves FIX.
REQ-031 Inputs outside the four listed funct3 codes are undefined; the block SHALL treat funct3[1] as the REM select and funct3[0] as the unsigned select.

Reset
REQ-032 While rst = 1, the block SHALL be in state IDLE with req_ready = 1, resp_valid = 0, div_start = 0, and resp_data, resp_tag, div_x, div_y all 0.
REQ-033 Reset asserted in any state SHALL abort the operation without emitting a response.
REQ-034 The core has no reset and may still be busy after rst; the next START SHALL restart the core, and any stale div_valid SHALL be ignored per REQ-024.

Verification
REQ-035 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> resp_data 0xFFFFFFFD after 35 cycles; REM with the same operands -> 0xFFFFFFFF.
REQ-036 DIVU 100/7 -> 14; REMU 100/7 -> 2; resp_tag equals req_tag; div_start pulses exactly once per request.
REQ-037 DIV x/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, both 1 cycle after accept, with div_start never asserted.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 via bypass; REM with the same operands -> 0.
REQ-039 Hold resp_ready = 0 for 10 cycles in RESP -> resp_valid, resp_data and resp_tag remain stable and req_ready stays 0; the response is released on resp_ready.
REQ-040 Assert rst in WAIT, then issue DIVU 9/3 immediately -> no response from the aborted request, and resp_data 3 after 35 cycles.
